// File: rtl/sprite_table_updater_if.sv
// Bus bundle for the sprite table updater: pass control, sprite RAM port and host write port.
interface sprite_table_updater_if #(
  parameter int unsigned NB = 5
);
  logic          start;
  logic          busy;
  logic          done;
  logic [NB+1:0] ram_addr;
  logic [7:0]    ram_rdata;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic          host_valid;
  logic          host_ready;
  logic [NB-1:0] host_index;
  logic [1:0]    host_field;
  logic [7:0]    host_data;

  modport master (
    output start, ram_rdata, host_valid, host_index, host_field, host_data,
    input  busy, done, ram_addr, ram_wdata, ram_we, host_ready
  );

  modport slave (
    input  start, ram_rdata, host_valid, host_index, host_field, host_data,
    output busy, done, ram_addr, ram_wdata, ram_we, host_ready
  );
endinterface

// File: rtl/sprite_table_updater.sv
// Per-frame sprite motion pass over the sprite attribute RAM (X wraps, Y bounces),
// plus a single-byte host write port usable while idle.
module sprite_table_updater #(
  parameter int unsigned NB   = 5,
  parameter int unsigned YMAX = 240
) (
  input logic                  clk,
  input logic                  reset,
  sprite_table_updater_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRd, StCalc, StWrX, StWrY, StWrV, StHostWr} state_e;

  state_e        state_q, state_d;
  logic [1:0]    rd_q, rd_d;
  logic [NB-1:0] cnt_q, cnt_d;
  logic [7:0]    x_q, x_d, y_q, y_d, v_q, v_d;
  logic [NB+1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;

  logic [NB-1:0] next_idx;
  logic [7:0]    x_new, y_new;
  logic [9:0]    y_sum;
  logic          y_under, y_over;
  logic [3:0]    vy_neg, vy_new;

  assign next_idx = cnt_q + 1'b1;

  // Motion arithmetic on the latched record; 10-bit two's complement keeps the sign of y + vy.
  assign x_new   = x_q + {{4{v_q[7]}}, v_q[7:4]};
  assign y_sum   = {2'b00, y_q} + {{6{v_q[3]}}, v_q[3:0]};
  assign y_under = y_sum[9];
  assign y_over  = !y_sum[9] && (y_sum[8:0] > 9'(YMAX));
  assign vy_neg  = (v_q[3:0] == 4'h8) ? 4'h7 : 4'h0 - v_q[3:0];
  assign vy_new  = (y_under || y_over) ? vy_neg : v_q[3:0];
  assign y_new   = y_under ? 8'h00 : (y_over ? 8'(YMAX) : y_sum[7:0]);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    v_d     = v_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRd;
          rd_d    = 2'd0;
          cnt_d   = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end else if (bus.host_valid) begin
          state_d = StHostWr;
          we_d    = 1'b1;
          addr_d  = {bus.host_index, bus.host_field};
          wdata_d = bus.host_data;
          ready_d = 1'b0;
        end
      end
      StHostWr: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
      StRd: begin
        rd_d = rd_q + 2'd1;
        // Read data trails the address by one cycle.
        case (rd_q)
          2'd0: addr_d = {cnt_q, 2'd1};
          2'd1: begin
            addr_d = {cnt_q, 2'd3};
            x_d    = bus.ram_rdata;
          end
          2'd2: y_d = bus.ram_rdata;
          default: begin
            v_d     = bus.ram_rdata;
            state_d = StCalc;
          end
        endcase
      end
      StCalc: begin
        x_d     = x_new;
        y_d     = y_new;
        v_d     = {v_q[7:4], vy_new};
        state_d = StWrX;
        we_d    = 1'b1;
        addr_d  = {cnt_q, 2'd0};
        wdata_d = x_new;
      end
      StWrX: begin
        state_d = StWrY;
        we_d    = 1'b1;
        addr_d  = {cnt_q, 2'd1};
        wdata_d = y_q;
      end
      StWrY: begin
        state_d = StWrV;
        we_d    = 1'b1;
        addr_d  = {cnt_q, 2'd3};
        wdata_d = v_q;
      end
      StWrV: begin
        if (cnt_q == '1) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          state_d = StRd;
          rd_d    = 2'd0;
          cnt_d   = next_idx;
          addr_d  = {next_idx, 2'd0};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rd_q    <= 2'd0;
      cnt_q   <= '0;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      v_q     <= 8'h00;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.ram_we     = we_q;
  assign bus.host_ready = ready_q;

endmodule

// File: tb/tb_sprite_table_updater.sv
// Self-checking bench: behavioural sprite RAM plus an integer-arithmetic motion model.
module tb_sprite_table_updater;
  localparam int unsigned NB   = 5;
  localparam int          N    = 1 << NB;
  localparam int          YMAX = 240;
  localparam int          PASS_LAT = N * 8 + 1;

  logic clk = 1'b0;
  logic reset;
  logic load;

  sprite_table_updater_if #(.NB(NB)) bus ();

  sprite_table_updater #(.NB(NB), .YMAX(YMAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem      [0:4*N-1];
  logic [7:0] init_mem [0:4*N-1];
  logic [7:0] shadow   [0:4*N-1];

  int n_checks = 0;
  int n_fail   = 0;

  // Registered-read RAM; `load` copies the bench image in one cycle while the DUT idles.
  always @(posedge clk) begin
    bus.ram_rdata <= mem[bus.ram_addr];
    if (load) begin
      for (int i = 0; i < 4 * N; i++) mem[i] <= init_mem[i];
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  int wr_cnt = 0, attr_wr_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (bus.ram_we) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.ram_addr[1:0] == 2'd2) attr_wr_cnt <= attr_wr_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [23:0] model_sprite(input logic [7:0] x, input logic [7:0] y,
                                               input logic [7:0] v);
    int vx, vy, nx, s, ny, nvy;
    vx = int'(v[7:4]);
    if (vx > 7) vx -= 16;
    vy = int'(v[3:0]);
    if (vy > 7) vy -= 16;
    nx  = (int'(x) + vx + 256) % 256;
    s   = int'(y) + vy;
    ny  = s;
    nvy = vy;
    if (s < 0) begin
      ny  = 0;
      nvy = -vy;
    end else if (s > YMAX) begin
      ny  = YMAX;
      nvy = -vy;
    end
    if (nvy > 7) nvy = 7;
    return {8'(nx), 8'(ny), v[7:4], 4'(nvy)};
  endfunction

  task automatic apply_model(input int first, input int count);
    logic [23:0] r;
    for (int i = first; i < first + count; i++) begin
      r = model_sprite(shadow[4*i], shadow[4*i+1], shadow[4*i+3]);
      shadow[4*i]   = r[23:16];
      shadow[4*i+1] = r[15:8];
      shadow[4*i+3] = r[7:0];
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4 * N; i++) shadow[i] = 8'($urandom);
  endtask

  task automatic load_ram();
    for (int i = 0; i < 4 * N; i++) init_mem[i] = shadow[i];
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called just after a negedge; returns in the HOST_WR cycle's following idle cycle.
  task automatic host_write(input int idx, input int field, input logic [7:0] data,
                            output logic ok, output logic we, output logic [NB+1:0] addr,
                            output logic [7:0] wdata);
    bus.host_valid = 1'b1;
    bus.host_index = NB'(idx);
    bus.host_field = 2'(field);
    bus.host_data  = data;
    ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bus.host_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.host_valid = 1'b0;
    we    = bus.ram_we;
    addr  = bus.ram_addr;
    wdata = bus.ram_wdata;
    shadow[4*idx+field] = data;
    @(negedge clk);
  endtask

  // Pulses start now; a second pulse at restart_at (0 = none). Ends at the negedge of done.
  task automatic run_pass(input int restart_at, output int lat, output int busy_bad,
                          output int writes, output int attr_writes);
    int w0, a0;
    w0 = wr_cnt;
    a0 = attr_wr_cnt;
    bus.start = 1'b1;
    lat = -1;
    busy_bad = 0;
    for (int c = 1; c <= PASS_LAT + 16; c++) begin
      @(negedge clk);
      if (c == 1 || c == restart_at + 1) bus.start = 1'b0;
      if (c == restart_at) bus.start = 1'b1;
      if (bus.done) begin
        lat = c;
        break;
      end
      if (!bus.busy || bus.host_ready) busy_bad++;
    end
    bus.start = 1'b0;
    writes = wr_cnt - w0;
    attr_writes = attr_wr_cnt - a0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.host_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.ram_we, bus.host_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/we/ready=%b expected 0001",
               {bus.busy, bus.done, bus.ram_we, bus.host_ready});
    end
    n_checks++;
    if (bus.ram_addr !== '0 || bus.ram_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%0h wdata=%0h expected 0 0", bus.ram_addr, bus.ram_wdata);
    end
    bus.start = 1'b0;
    bus.host_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0 || bus.host_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b we=%b ready=%b expected 0 0 1",
               bus.busy, bus.ram_we, bus.host_ready);
    end
  endtask

  task automatic test_host_then_pass();
    logic ok, we;
    logic [NB+1:0] addr;
    logic [7:0] wdata;
    logic [7:0] vals [3];
    int flds [3];
    int lat, bb, wr, aw;
    vals = '{8'd10, 8'd20, 8'h21};
    flds = '{0, 1, 3};
    fill_random();
    load_ram();
    for (int k = 0; k < 3; k++) begin
      host_write(3, flds[k], vals[k], ok, we, addr, wdata);
      n_checks++;
      if (!ok || we !== 1'b1 || addr !== {NB'(3), 2'(flds[k])} || wdata !== vals[k]) begin
        n_fail++;
        $display("FAIL host_wr%0d: got ok=%b we=%b addr=%0h data=%0h expected 1 1 %0h %0h",
                 k, ok, we, addr, wdata, {NB'(3), 2'(flds[k])}, vals[k]);
      end
    end
    apply_model(0, N);
    run_pass(0, lat, bb, wr, aw);
    n_checks++;
    if (lat != PASS_LAT || bb != 0) begin
      n_fail++;
      $display("FAIL pass_timing: got done_at=%0d busy_bad=%0d expected %0d 0", lat, bb, PASS_LAT);
    end
    n_checks++;
    if (wr != 3 * N || aw != 0) begin
      n_fail++;
      $display("FAIL pass_writes: got writes=%0d attr=%0d expected %0d 0", wr, aw, 3 * N);
    end
    n_checks++;
    if ({mem[12], mem[13], mem[15]} !== {8'd12, 8'd21, 8'h21}) begin
      n_fail++;
      $display("FAIL host_sprite3: got %h expected 0c1521", {mem[12], mem[13], mem[15]});
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]} !==
          {shadow[4*i], shadow[4*i+1], shadow[4*i+2], shadow[4*i+3]}) begin
        n_fail++;
        $display("FAIL pass1_sprite%0d: got %h expected %h", i,
                 {mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]},
                 {shadow[4*i], shadow[4*i+1], shadow[4*i+2], shadow[4*i+3]});
      end
    end
  endtask

  task automatic test_wrap_bounce();
    int lat, bb, wr, aw;
    fill_random();
    shadow[0]  = 8'd254; shadow[3]  = 8'h30;
    shadow[4]  = 8'd2;   shadow[7]  = 8'hC0;
    shadow[9]  = 8'd238; shadow[11] = 8'h05;
    shadow[13] = 8'd3;   shadow[15] = 8'h0C;
    shadow[17] = 8'd2;   shadow[19] = 8'h08;
    load_ram();
    apply_model(0, N);
    run_pass(0, lat, bb, wr, aw);
    n_checks++;
    if (mem[0] !== 8'd1 || mem[4] !== 8'd254) begin
      n_fail++;
      $display("FAIL x_wrap: got x0=%0d x1=%0d expected 1 254", mem[0], mem[4]);
    end
    n_checks++;
    if ({mem[9], mem[11]} !== {8'd240, 8'h0B}) begin
      n_fail++;
      $display("FAIL y_top_bounce: got y=%0d v=%h expected 240 0b", mem[9], mem[11]);
    end
    n_checks++;
    if ({mem[13], mem[15]} !== {8'd0, 8'h04}) begin
      n_fail++;
      $display("FAIL y_bottom_bounce: got y=%0d v=%h expected 0 04", mem[13], mem[15]);
    end
    n_checks++;
    if ({mem[17], mem[19]} !== {8'd0, 8'h07}) begin
      n_fail++;
      $display("FAIL vy_saturate: got y=%0d v=%h expected 0 07", mem[17], mem[19]);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]} !==
          {shadow[4*i], shadow[4*i+1], shadow[4*i+2], shadow[4*i+3]}) begin
        n_fail++;
        $display("FAIL wrap_sprite%0d: got %h expected %h", i,
                 {mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]},
                 {shadow[4*i], shadow[4*i+1], shadow[4*i+2], shadow[4*i+3]});
      end
    end
  endtask

  task automatic test_random_passes();
    int lat, bb, wr, aw, bad;
    fill_random();
    load_ram();
    // Consecutive passes over evolving state, no reload in between.
    for (int it = 0; it < 3; it++) begin
      apply_model(0, N);
      run_pass(0, lat, bb, wr, aw);
      n_checks++;
      if (lat != PASS_LAT || bb != 0 || wr != 3 * N) begin
        n_fail++;
        $display("FAIL rand_pass%0d_timing: got done_at=%0d busy_bad=%0d writes=%0d expected %0d 0 %0d",
                 it, lat, bb, wr, PASS_LAT, 3 * N);
      end
      bad = 0;
      for (int i = 0; i < 4 * N; i++) if (mem[i] !== shadow[i]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL rand_pass%0d_data: got %0d wrong bytes expected 0", it, bad);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_arbitration();
    int lat, bb, wr, aw, bad;
    logic [7:0] attr;
    attr = 8'($urandom);
    fill_random();
    load_ram();
    apply_model(0, N);
    bus.host_valid = 1'b1;
    bus.host_index = NB'(7);
    bus.host_field = 2'd2;
    bus.host_data  = attr;
    run_pass(100, lat, bb, wr, aw);
    n_checks++;
    if (lat != PASS_LAT || bb != 0) begin
      n_fail++;
      $display("FAIL arb_pass: got done_at=%0d busy_or_ready_bad=%0d expected %0d 0",
               lat, bb, PASS_LAT);
    end
    n_checks++;
    if (bus.host_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_ready_at_done: got %b expected 1", bus.host_ready);
    end
    @(negedge clk);
    bus.host_valid = 1'b0;
    n_checks++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== {NB'(7), 2'd2} || bus.ram_wdata !== attr) begin
      n_fail++;
      $display("FAIL arb_host_after_done: got we=%b addr=%0h data=%0h expected 1 %0h %0h",
               bus.ram_we, bus.ram_addr, bus.ram_wdata, {NB'(7), 2'd2}, attr);
    end
    shadow[4*7+2] = attr;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || wr != 3 * N) begin
      n_fail++;
      $display("FAIL arb_restart_ignored: got busy=%b writes=%0d expected 0 %0d",
               bus.busy, wr, 3 * N);
    end
    bad = 0;
    for (int i = 0; i < 4 * N; i++) if (mem[i] !== shadow[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL arb_data: got %0d wrong bytes expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_pass();
    int w0, d0, bad;
    fill_random();
    load_ram();
    apply_model(0, 4);
    d0 = done_cnt;
    bus.start = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.ram_we, bus.busy, bus.done, bus.host_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_outputs: got we/busy/done/ready=%b expected 0001",
               {bus.ram_we, bus.busy, bus.done, bus.host_ready});
    end
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_cnt != w0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got writes=%0d dones=%0d expected 0 0",
               wr_cnt - w0, done_cnt - d0);
    end
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (i == 4) continue;
      for (int f = 0; f < 4; f++) if (mem[4*i+f] !== shadow[4*i+f]) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset_data: got %0d wrong bytes expected 0", bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    bus.start = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_index = '0;
    bus.host_field = 2'd0;
    bus.host_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_host_then_pass();
    test_wrap_bounce();
    test_random_passes();
    test_arbitration();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
